// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the fetch PC, issues one-at-a-time word reads
// over a req/ack handshake, and buffers returned words in a small FIFO whose
// head is presented to the decoder. Redirects flush buffered words and drop
// the response of an in-flight request. Opcode-0 words stop fetching (HALT).
// Optional performance counters are enabled by defining IFETCH_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instruction,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  consume,
  input  logic                  pc_enable,
  input  logic                  jump_taken,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic                  halted
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           flush_count
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] fetch_pc_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  req_reg;
  logic                  drop_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W-1:0]      wr_ptr_reg;

  logic [31:0]           buf_word [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc   [BUF_DEPTH];

  logic ack_live;
  logic do_issue;
  logic do_enq;
  logic do_deq;
  logic rdata_is_halt;

  // Event decode: redirect suppresses issue, enqueue and dequeue this cycle.
  always_comb begin
    ack_live      = (state_reg == WAIT) && imem_ack;
    do_issue      = (state_reg == ISSUE) && (cnt_reg < FULL_CNT) && !jump_taken;
    do_enq        = ack_live && !drop_reg && !jump_taken;
    do_deq        = (cnt_reg != '0) && consume && pc_enable && !jump_taken;
    rdata_is_halt = (imem_rdata[31:26] == 6'd0);
  end

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ISSUE;
    else     state_reg <= state_next;
  end

  // Fetch FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ISSUE: begin
        if (do_issue) state_next = WAIT;
      end
      WAIT: begin
        // Without an ack a redirect keeps us waiting for the response to drop.
        if (ack_live) begin
          if (jump_taken || drop_reg) state_next = ISSUE;
          else if (rdata_is_halt)     state_next = HALT;
          else                        state_next = ISSUE;
        end
      end
      HALT: begin
        if (jump_taken) state_next = ISSUE;
      end
      default: state_next = ISSUE;
    endcase
  end

  // Request port, fetch PC and drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_reg      <= 1'b0;
      addr_reg     <= RESET_PC;
      fetch_pc_reg <= RESET_PC;
      drop_reg     <= 1'b0;
    end else begin
      if (do_issue) begin
        req_reg  <= 1'b1;
        addr_reg <= fetch_pc_reg;
      end else if (ack_live) begin
        req_reg  <= 1'b0;
      end

      if (jump_taken)  fetch_pc_reg <= jump_target & ~ADDR_WIDTH'(3);
      else if (do_enq) fetch_pc_reg <= fetch_pc_reg + ADDR_WIDTH'(4);

      // Only one response is ever dropped, however many redirects arrive.
      if (jump_taken && (state_reg == WAIT) && !imem_ack) drop_reg <= 1'b1;
      else if (ack_live)                                  drop_reg <= 1'b0;
    end
  end

  // Buffer occupancy and pointers; a redirect empties the buffer.
  always_ff @(posedge clk) begin
    if (rst || jump_taken) begin
      cnt_reg    <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      if (do_enq) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_deq) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_enq, do_deq})
        2'b10:   cnt_reg <= cnt_reg + CNT_W'(1);
        2'b01:   cnt_reg <= cnt_reg - CNT_W'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // Buffer storage; entries need no reset because occupancy qualifies them.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      buf_word[wr_ptr_reg] <= imem_rdata;
      buf_pc[wr_ptr_reg]   <= fetch_pc_reg;
    end
  end

  // Decoder-facing outputs come from the buffer head only.
  always_comb begin
    instr_valid = (cnt_reg != '0);
    instruction = instr_valid ? buf_word[rd_ptr_reg] : 32'd0;
    instr_pc    = instr_valid ? buf_pc[rd_ptr_reg] : '0;
    halted      = (state_reg == HALT) && instr_valid && (instruction[31:26] == 6'd0);
    imem_req    = req_reg;
    imem_addr   = addr_reg;
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count_reg;
  logic [31:0] flush_count_reg;

  // Count accepted fetches and redirects; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_reg <= 32'd0;
      flush_count_reg <= 32'd0;
    end else begin
      if (do_enq)     fetch_count_reg <= fetch_count_reg + 32'd1;
      if (jump_taken) flush_count_reg <= flush_count_reg + 32'd1;
    end
  end

  assign fetch_count = fetch_count_reg;
  assign flush_count = flush_count_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// traffic, all checked each cycle against a queue-based reference model.
module tb_instruction_fetch_unit;

  localparam int BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        consume;
  logic        pc_enable;
  logic        jump_taken;
  logic [31:0] jump_target;
  logic        halted;

  instruction_fetch_unit #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'd0),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .instr_pc   (instr_pc),
    .consume    (consume),
    .pc_enable  (pc_enable),
    .jump_taken (jump_taken),
    .jump_target(jump_target),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: buffered words as a queue plus a few mode flags.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_addr;
  bit          m_req;
  bit          m_drop;
  bit          m_halt;

  // Memory model state and stimulus knobs.
  bit mem_busy;
  int mem_lat;
  bit late_ack;
  int lat_min = 0;
  int lat_max = 0;
  bit pe_rand = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a == 32'd0) return 32'h0422_1800;
    if (a == 32'd4) return 32'h0843_0800;
    if (a == 32'd8) return 32'h0000_0000;
    w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (((a >> 2) % 7) == 3)      w[31:26] = 6'd0;
    else if (w[31:26] == 6'd0)    w[31:26] = 6'd1;
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    m_fpc  = 32'd0;
    m_addr = 32'd0;
    m_req  = 0;
    m_drop = 0;
    m_halt = 0;
  endtask

  task automatic model_update(input bit r, input bit c, input bit pe, input bit jt,
                              input logic [31:0] jtgt, input bit ack, input logic [31:0] rd);
    int occ;
    bit ack_live;
    occ = q.size();
    if (r) begin
      model_reset();
      return;
    end
    ack_live = m_req && ack;
    if (jt) begin
      q.delete();
      m_fpc  = jtgt & ~32'h3;
      m_halt = 0;
      if (ack_live) begin
        m_req  = 0;
        m_drop = 0;
      end else if (m_req) begin
        m_drop = 1;
      end
    end else begin
      if (occ > 0 && c && pe) void'(q.pop_front());
      if (ack_live) begin
        m_req = 0;
        if (m_drop) m_drop = 0;
        else begin
          q.push_back('{pc: m_fpc, word: rd});
          m_fpc = m_fpc + 32'd4;
          if (rd[31:26] == 6'd0) m_halt = 1;
        end
      end else if (!m_req && !m_halt && occ < BUF_DEPTH) begin
        m_req  = 1;
        m_addr = m_fpc;
      end
    end
  endtask

  task automatic compare_outputs();
    bit          hv;
    logic [31:0] hw;
    logic [31:0] hp;
    hv = (q.size() != 0);
    hw = hv ? q[0].word : 32'd0;
    hp = hv ? q[0].pc : 32'd0;
    chk("imem_req", 64'(imem_req), 64'(m_req));
    chk("imem_addr", 64'(imem_addr), 64'(m_addr));
    chk("instr_valid", 64'(instr_valid), 64'(hv));
    chk("instruction", 64'(instruction), 64'(hw));
    chk("instr_pc", 64'(instr_pc), 64'(hp));
    chk("halted", 64'(halted), 64'(m_halt && hv && hw[31:26] == 6'd0));
  endtask

  // One clock: check at negedge, drive inputs, update model after the edge.
  task automatic step(input bit r, input bit c, input bit jt, input logic [31:0] jtgt);
    @(negedge clk);
    compare_outputs();
    rst         = r;
    consume     = c;
    jump_taken  = jt;
    jump_target = jtgt;
    if (q.size() > 0 && q[0].word[31:26] == 6'd0) pc_enable = 1'b0;
    else pc_enable = pe_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (late_ack) begin
      imem_ack = 1'b1;
      late_ack = 0;
    end else if (m_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_lat  = $urandom_range(lat_min, lat_max);
      end
      if (mem_lat == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(m_addr);
        mem_busy   = 0;
      end else begin
        mem_lat--;
      end
    end
    if (r && mem_busy) begin
      mem_busy = 0;
      late_ack = 1;
    end
    @(posedge clk);
    model_update(r, c, pc_enable, jt, jtgt, imem_ack, imem_rdata);
    #1;
  endtask

  int seen12;
  int nreq;
  int rsts;
  int jmps;

  initial begin
    rst = 1'b1; consume = 1'b0; pc_enable = 1'b1; jump_taken = 1'b0;
    jump_target = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;
    mem_busy = 0; mem_lat = 0; late_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Scenario 1: latency-1 memory, consume held, stream ending in a halt word.
    lat_min = 0; lat_max = 0; pe_rand = 0;
    step(1, 1, 0, 0);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instruction), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    step(0, 1, 0, 0);
    chk("s1_first_req", 64'(imem_req), 64'd1);
    chk("s1_first_addr", 64'(imem_addr), 64'd0);
    step(0, 1, 0, 0);
    chk("s1_first_valid", 64'(instr_valid), 64'd1);
    chk("s1_first_word", 64'(instruction), 64'h0422_1800);
    seen12 = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0);
      if (imem_req && imem_addr == 32'd12) seen12++;
    end
    chk("s1_halted", 64'(halted), 64'd1);
    chk("s1_halt_pc", 64'(instr_pc), 64'd8);
    chk("s1_no_req12", 64'(seen12), 64'd0);

    // Scenario 2: redirect out of HALT.
    step(0, 1, 1, 32'h40);
    chk("s2_halt_clear", 64'(halted), 64'd0);
    chk("s2_flushed", 64'(instr_valid), 64'd0);
    step(0, 0, 0, 0);
    chk("s2_req", 64'(imem_req), 64'd1);
    chk("s2_addr", 64'(imem_addr), 64'h40);

    // Scenario 3: decoder stalled; buffer fills, then fetch resumes at 8.
    step(1, 0, 0, 0);
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0);
      if (imem_req) nreq++;
    end
    chk("s3_nreq", 64'(nreq), 64'(BUF_DEPTH));
    chk("s3_req_idle", 64'(imem_req), 64'd0);
    chk("s3_head_pc", 64'(instr_pc), 64'd0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("s3_resume_req", 64'(imem_req), 64'd1);
    chk("s3_resume_addr", 64'(imem_addr), 64'd8);

    // Scenario 4: latency-3 memory, redirect while a request is in flight.
    lat_min = 2; lat_max = 2;
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'h10);
    step(0, 0, 0, 0);
    chk("s4_req", 64'(imem_req), 64'd1);
    chk("s4_addr", 64'(imem_addr), 64'h10);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h103);
    chk("s4_addr_hold", 64'(imem_addr), 64'h10);
    step(0, 0, 0, 0);
    chk("s4_dropped", 64'(instr_valid), 64'd0);
    for (int i = 0; i < 20 && !instr_valid; i++) step(0, 0, 0, 0);
    chk("s4_valid", 64'(instr_valid), 64'd1);
    chk("s4_pc", 64'(instr_pc), 64'h100);

    // Scenario 5: redirect coincident with ack and consume, one entry buffered.
    lat_min = 0; lat_max = 0;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("s5_pre_valid", 64'(instr_valid), 64'd1);
    chk("s5_pre_addr", 64'(imem_addr), 64'd4);
    step(0, 1, 1, 32'h200);
    chk("s5_empty", 64'(instr_valid), 64'd0);
    chk("s5_req_low", 64'(imem_req), 64'd0);
    step(0, 0, 0, 0);
    chk("s5_target_addr", 64'(imem_addr), 64'h200);

    // Random traffic against the model.
    lat_min = 0; lat_max = 3; pe_rand = 1;
    rsts = 0; jmps = 0;
    for (int i = 0; i < 3000; i++) begin
      bit          r;
      bit          jt;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 499) == 0);
      jt  = ($urandom_range(0, 15) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                        : 32'($urandom_range(0, 511));
      if (r) rsts++;
      if (jt) jmps++;
      step(r, $urandom_range(0, 3) != 0, jt, tgt);
    end
    step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
